pool_fmap_flattener: RTL and testbench
======================================

// Module: pool_fmap_flattener
// PURPOSE
//  Receiving end of the pooling-core output stream of cnn_top. Captures one pooled frame
//  (POOL_W x POOL_H positions, CO channels packed per beat) into a ping-pong buffer, then
//  replays it channel-major (ch, row, col) as a one-element-per-beat valid/ready stream
//  for the fully-connected stage. Pooling core has no backpressure; buffering absorbs it.
// PARAMETERS
//  CO      3    channels per input beat
//  O_F_BW  20   bits per channel element, signed two's complement, passed through unchanged
//  POOL_W  12   pooled map width  ((28-5+1)/2)
//  POOL_H  12   pooled map height
// PORTS
//  clk          in   1            single clock, all logic on rising edge
//  reset        in   1            asynchronous, active-high; clears all state
//  i_valid      in   1            pooling-core beat valid (w_pooling_core_valid)
//  i_fmap       in   CO*O_F_BW    packed beat; channel c at [c*O_F_BW +: O_F_BW]
//  o_valid      out  1            output element valid
//  o_data       out  O_F_BW       output element
//  o_ch         out  $clog2(CO)   channel index of o_data
//  o_last       out  1            high with final element of a frame (c=CO-1, p=N-1)
//  i_ready      in   1            downstream accept; transfer when o_valid && i_ready
//  o_overflow   out  1            sticky: an input beat was dropped
//  o_busy       out  1            any bank full or draining
// BEHAVIOUR
//  - N = POOL_W*POOL_H (144). Two banks, each N x CO*O_F_BW. Flags full[1:0], wr_bank, wr_idx.
//  - Reset: o_valid=0, o_data=0, o_ch=0, o_last=0, o_overflow=0, o_busy=0, full=00,
//    wr_bank=0, wr_idx=0, rd FSM IDLE. Reset mid-frame discards everything.
//  - Write: beat accepted iff i_valid && (!full[wr_bank] || release[wr_bank] this cycle).
//    Stored at bank[wr_bank][wr_idx]; wr_idx++; at wr_idx==N-1: full[wr_bank]<=1,
//    wr_bank toggles, wr_idx<=0. Non-accepted i_valid: beat dropped, o_overflow<=1, wr_idx holds.
//  - Read FSM: IDLE -> FETCH when full[rd_bank]; FETCH issues sync RAM read (1 cycle) ->
//    PRESENT loads o_data/o_ch/o_last, o_valid=1. On handshake: advance p (inner) then c
//    (outer); next element registered with no bubble (prefetch address), so sustained
//    throughput is 1 elem/cycle while i_ready=1. o_valid, o_data, o_ch, o_last stable while
//    o_valid && !i_ready.
//  - Latency: full[b] rises at cycle t -> first o_valid at t+2 (IDLE->FETCH->PRESENT).
//  - Frame end: handshake with o_last=1 -> release[rd_bank] pulse, full[rd_bank]<=0,
//    rd_bank toggles; if other bank already full, FETCH next cycle, else IDLE, o_valid=0.
//  - Simultaneous release and write to same bank: write accepted (release wins first).
//  - Same-bank RAM read/write conflict impossible by construction (write only to non-full bank).
//  - Element order: frame element k = c*N + p, p = row*POOL_W + col, o_data =
//    bank[rd_bank][p][c*O_F_BW +: O_F_BW].
//  - o_busy = |full || (state != IDLE).
// STRUCTURE
//  - cnn_pkg: CO, O_F_BW, POOL_W, POOL_H, N_POOL = POOL_W*POOL_H, rd_state_t enum
//    {IDLE, FETCH, PRESENT}; shared with cnn_top and the FC layer.
//  - One sub-module: fmap_bank_ram (simple dual-port, 1 write / 1 sync-read, depth 2*N,
//    address {bank, idx}, width CO*O_F_BW). Write counters, flags and read FSM in top.
// TESTING
//  1 Reset, stream 144 beats with i_fmap = {ch2=p+200, ch1=p+100, ch0=p}, i_ready=1 ->
//    432 outputs: 0..143 (o_ch=0), 100..243, 200..343; o_last only on 432nd; first o_valid 2 cycles after beat 144.
//  2 Same frame, i_ready toggled pseudo-random -> identical sequence, o_data held stable
//    during every stall, no duplicates or drops.
//  3 Two back-to-back frames with i_ready=0 until both stored, then 3rd frame beat ->
//    beat dropped, o_overflow=1 sticky; release i_ready -> frames 1 then 2 replayed intact.
//  4 Negative data (ch0 = -1 = 20'hFFFFF, ch1 = -524288) -> emitted bit-exact.
//  5 Assert reset at beat 70 of frame and mid-drain (element 200) -> next cycle o_valid=0,
//    o_busy=0, o_overflow=0; a following full frame replays from element 0 correctly.
//  6 Frame 2's first beat arrives in the same cycle frame 1's o_last handshakes with both
//    banks full -> beat accepted, o_overflow stays 0.

Source files
------------

// File: rtl/pool_fmap_flattener_pkg.sv
// Shared constants and types for the pooled-feature-map flattener.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package pool_fmap_flattener_pkg;

    localparam int CO        = 3;                  // channels per input beat
    localparam int O_F_BW    = 20;                 // bits per channel element (signed)
    localparam int POOL_W    = 12;                 // pooled map width
    localparam int POOL_H    = 12;                 // pooled map height
    localparam int N_POOL    = POOL_W * POOL_H;    // positions per frame
    localparam int IDX_W     = $clog2(N_POOL);
    localparam int CH_W      = $clog2(CO);
    localparam int BEAT_W    = CO * O_F_BW;
    localparam int RAM_DEPTH = 2 * N_POOL;
    localparam int ADDR_W    = $clog2(RAM_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        PRESENT
    } rd_state_t;

    // Banks are packed back to back: bank 1 starts at N_POOL rather than at a power of two.
    function automatic logic [ADDR_W-1:0] bank_addr(input logic bank, input logic [IDX_W-1:0] idx);
        return bank ? (ADDR_W'(N_POOL) + ADDR_W'(idx)) : ADDR_W'(idx);
    endfunction

endpackage

// File: rtl/pool_fmap_flattener_bank_ram.sv
// Ping-pong frame store: simple dual-port RAM, one write port and one registered read port.
// Latency: read data valid one cycle after re; write visible to reads on the following cycle.
// Backpressure: none; rdata holds its value whenever re is low.
// Ports: clk, reset (async, clears rdata only), we/waddr/wdata write port,
//        re/raddr read request, rdata registered read data.
module pool_fmap_flattener_bank_ram #(
    parameter int WIDTH  = 60,
    parameter int DEPTH  = 288,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/pool_fmap_flattener.sv
// Captures pooled frames (N_POOL beats of CO channels) into two banks and replays each
// channel-major as one element per beat. Latency: bank full -> first o_valid 2 cycles later.
// Backpressure: i_ready stalls the replay; input has none, beats with no free bank are dropped.
// Ports: clk, reset (async active-high); i_valid/i_fmap pooled beat in;
//        o_valid/o_data/o_ch/o_last element out with i_ready accept;
//        o_overflow sticky drop flag; o_busy any bank full or replay active.
module pool_fmap_flattener
    import pool_fmap_flattener_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              i_valid,
    input  logic [BEAT_W-1:0] i_fmap,
    output logic              o_valid,
    output logic [O_F_BW-1:0] o_data,
    output logic [CH_W-1:0]   o_ch,
    output logic              o_last,
    input  logic              i_ready,
    output logic              o_overflow,
    output logic              o_busy
);

    logic [1:0]        full;
    logic              wr_bank;
    logic [IDX_W-1:0]  wr_idx;
    logic              wr_accept;
    logic              wr_last;

    logic              rd_bank;
    rd_state_t         state;
    rd_state_t         state_nxt;
    logic [IDX_W-1:0]  rd_p;
    logic [CH_W-1:0]   rd_c;
    logic [IDX_W-1:0]  p_nxt;
    logic [CH_W-1:0]   c_nxt;

    logic              hs;
    logic              frame_done;
    logic [1:0]        release_vec;

    logic              ram_re;
    logic [ADDR_W-1:0] ram_raddr;
    logic [BEAT_W-1:0] ram_rdata;

    assign hs          = o_valid && i_ready;
    assign frame_done  = hs && o_last;
    assign release_vec = frame_done ? (rd_bank ? 2'b10 : 2'b01) : 2'b00;

    // A bank being released this cycle can take the first beat of the next frame.
    assign wr_accept = i_valid && (!full[wr_bank] || release_vec[wr_bank]);
    assign wr_last   = wr_accept && (wr_idx == IDX_W'(N_POOL - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_bank    <= 1'b0;
            wr_idx     <= '0;
            o_overflow <= 1'b0;
        end else begin
            if (wr_accept) begin
                if (wr_last) begin
                    wr_idx  <= '0;
                    wr_bank <= ~wr_bank;
                end else begin
                    wr_idx <= wr_idx + 1'b1;
                end
            end
            if (i_valid && !wr_accept) begin
                o_overflow <= 1'b1;
            end
        end
    end

    // Clear before set: the filling bank is never the one being released on its last beat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full <= 2'b00;
        end else begin
            full <= (full & ~release_vec) | (wr_last ? (wr_bank ? 2'b10 : 2'b01) : 2'b00);
        end
    end

    // Position is the inner loop, channel the outer one.
    always_comb begin
        p_nxt = rd_p + 1'b1;
        c_nxt = rd_c;
        if (rd_p == IDX_W'(N_POOL - 1)) begin
            p_nxt = '0;
            c_nxt = rd_c + 1'b1;
        end
    end

    // The read address always points at the element after the one on display, so a
    // handshake reloads the RAM output register in the same edge and no bubble appears.
    always_comb begin
        state_nxt = state;
        ram_re    = 1'b0;
        ram_raddr = bank_addr(rd_bank, p_nxt);
        case (state)
            IDLE: begin
                if (full[rd_bank]) begin
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                ram_re    = 1'b1;
                ram_raddr = bank_addr(rd_bank, '0);
                state_nxt = PRESENT;
            end
            PRESENT: begin
                if (frame_done) begin
                    state_nxt = full[~rd_bank] ? FETCH : IDLE;
                end else if (hs) begin
                    ram_re = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            rd_bank <= 1'b0;
            rd_p    <= '0;
            rd_c    <= '0;
        end else begin
            state <= state_nxt;
            if (frame_done) begin
                rd_bank <= ~rd_bank;
            end
            if (state == FETCH) begin
                rd_p <= '0;
                rd_c <= '0;
            end else if (hs && !o_last) begin
                rd_p <= p_nxt;
                rd_c <= c_nxt;
            end
        end
    end

    pool_fmap_flattener_bank_ram #(
        .WIDTH  (BEAT_W),
        .DEPTH  (RAM_DEPTH),
        .ADDR_W (ADDR_W)
    ) u_bank_ram (
        .clk   (clk),
        .reset (reset),
        .we    (wr_accept),
        .waddr (bank_addr(wr_bank, wr_idx)),
        .wdata (i_fmap),
        .re    (ram_re),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    // Output fields come straight from registers, so they hold while stalled.
    assign o_valid = (state == PRESENT);
    assign o_ch    = rd_c;
    assign o_data  = ram_rdata[rd_c * O_F_BW +: O_F_BW];
    assign o_last  = o_valid && (rd_c == CH_W'(CO - 1)) && (rd_p == IDX_W'(N_POOL - 1));
    assign o_busy  = (|full) || (state != IDLE);

endmodule

// File: tb/tb_pool_fmap_flattener.sv
module tb_pool_fmap_flattener;
    import pool_fmap_flattener_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic              i_valid;
    logic [BEAT_W-1:0] i_fmap;
    logic              o_valid;
    logic [O_F_BW-1:0] o_data;
    logic [CH_W-1:0]   o_ch;
    logic              o_last;
    logic              i_ready;
    logic              o_overflow;
    logic              o_busy;

    pool_fmap_flattener dut (
        .clk        (clk),
        .reset      (reset),
        .i_valid    (i_valid),
        .i_fmap     (i_fmap),
        .o_valid    (o_valid),
        .o_data     (o_data),
        .o_ch       (o_ch),
        .o_last     (o_last),
        .i_ready    (i_ready),
        .o_overflow (o_overflow),
        .o_busy     (o_busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [O_F_BW-1:0] d;
        logic [CH_W-1:0]   ch;
        logic              last;
    } exp_t;

    exp_t sb[$];
    int   checks  = 0;
    int   errors  = 0;
    int   n_out   = 0;
    int   n_stall = 0;

    function automatic logic [BEAT_W-1:0] beat(input int kind, input int p);
        logic [O_F_BW-1:0] c0, c1, c2;
        case (kind)
            0: begin
                c0 = O_F_BW'(p);
                c1 = O_F_BW'(p + 100);
                c2 = O_F_BW'(p + 200);
            end
            1: begin
                c0 = 20'hFFFFF;
                c1 = 20'h80000;
                c2 = O_F_BW'(-(p + 1));
            end
            default: begin
                c0 = O_F_BW'(kind * 1000 + p);
                c1 = O_F_BW'(kind * 1000 + p + 100);
                c2 = O_F_BW'(kind * 1000 + p + 200);
            end
        endcase
        return {c2, c1, c0};
    endfunction

    task automatic push_frame(input int kind);
        logic [BEAT_W-1:0] b;
        exp_t e;
        for (int c = 0; c < CO; c++) begin
            for (int p = 0; p < N_POOL; p++) begin
                b      = beat(kind, p);
                e.d    = b[c * O_F_BW +: O_F_BW];
                e.ch   = CH_W'(c);
                e.last = (c == CO - 1) && (p == N_POOL - 1);
                sb.push_back(e);
            end
        end
    endtask

    task automatic drive_beats(input int kind, input int from, input int to);
        for (int p = from; p <= to; p++) begin
            i_valid = 1'b1;
            i_fmap  = beat(kind, p);
            @(posedge clk);
            #1;
        end
        i_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        i_valid = 1'b0;
        i_ready = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        sb.delete();
        n_out = 0;
    endtask

    task automatic wait_drain(input int mode, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 8000; i++) begin
            i_ready = (mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk);
            #1;
            if (sb.size() == 0 && !o_busy) begin
                ok = 1'b1;
                break;
            end
        end
        i_ready = 1'b1;
    endtask

    // Scoreboard and stall-stability monitor.
    initial begin : monitor
        bit   prev_stall;
        exp_t held;
        exp_t e;
        prev_stall = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_stall = 1'b0;
            end else if (o_valid) begin
                if (prev_stall) begin
                    checks++;
                    if ({o_data, o_ch, o_last} !== held) begin
                        errors++;
                        $display("FAIL stall_hold: got d=%h ch=%0d last=%0b required d=%h ch=%0d last=%0b",
                                 o_data, o_ch, o_last, held.d, held.ch, held.last);
                    end
                end
                if (i_ready) begin
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_elem: got d=%h ch=%0d with empty scoreboard", o_data, o_ch);
                    end else begin
                        e = sb.pop_front();
                        if ({o_data, o_ch, o_last} !== e) begin
                            errors++;
                            $display("FAIL elem_%0d: got d=%h ch=%0d last=%0b required d=%h ch=%0d last=%0b",
                                     n_out, o_data, o_ch, o_last, e.d, e.ch, e.last);
                        end
                    end
                    n_out++;
                    prev_stall = 1'b0;
                end else begin
                    n_stall++;
                    prev_stall = 1'b1;
                    held = {o_data, o_ch, o_last};
                end
            end else begin
                if (prev_stall) begin
                    checks++;
                    errors++;
                    $display("FAIL stall_valid_drop: got o_valid=0 required 1");
                end
                prev_stall = 1'b0;
            end
        end
    end

    task automatic test_reset();
        do_reset();
        reset = 1'b1;
        @(negedge clk);
        checks++; if (o_valid !== 1'b0)    begin errors++; $display("FAIL reset_o_valid: got %b required 0", o_valid); end
        checks++; if (o_data !== '0)       begin errors++; $display("FAIL reset_o_data: got %h required 0", o_data); end
        checks++; if (o_ch !== '0)         begin errors++; $display("FAIL reset_o_ch: got %0d required 0", o_ch); end
        checks++; if (o_last !== 1'b0)     begin errors++; $display("FAIL reset_o_last: got %b required 0", o_last); end
        checks++; if (o_overflow !== 1'b0) begin errors++; $display("FAIL reset_o_overflow: got %b required 0", o_overflow); end
        checks++; if (o_busy !== 1'b0)     begin errors++; $display("FAIL reset_o_busy: got %b required 0", o_busy); end
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_stream();
        int lat;
        bit seen;
        bit ok;
        n_out   = 0;
        i_ready = 1'b1;
        drive_beats(0, 0, N_POOL - 1);
        push_frame(0);
        lat  = 0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (o_valid) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        checks++;
        if (!seen || lat != 2) begin
            errors++;
            $display("FAIL stream_latency: got seen=%0b cycles=%0d required seen=1 cycles=2", seen, lat);
        end
        wait_drain(0, ok);
        checks++; if (!ok)          begin errors++; $display("FAIL stream_drain: got timeout required drained"); end
        checks++; if (n_out != 432) begin errors++; $display("FAIL stream_count: got %0d required 432", n_out); end
    endtask

    task automatic test_stall();
        bit ok;
        int stalls0;
        n_out   = 0;
        stalls0 = n_stall;
        drive_beats(0, 0, N_POOL - 1);
        push_frame(0);
        wait_drain(1, ok);
        checks++; if (!ok)               begin errors++; $display("FAIL stall_drain: got timeout required drained"); end
        checks++; if (n_out != 432)      begin errors++; $display("FAIL stall_count: got %0d required 432", n_out); end
        checks++; if (n_stall == stalls0) begin errors++; $display("FAIL stall_seen: got 0 stalls required >0"); end
    endtask

    task automatic test_overflow();
        bit ok;
        n_out   = 0;
        i_ready = 1'b0;
        drive_beats(2, 0, N_POOL - 1);
        push_frame(2);
        drive_beats(3, 0, N_POOL - 1);
        push_frame(3);
        checks++; if (o_overflow !== 1'b0) begin errors++; $display("FAIL ovf_before: got %b required 0", o_overflow); end
        drive_beats(4, 0, 0);
        checks++; if (o_overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b required 1", o_overflow); end
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        checks++; if (o_overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b required 1", o_overflow); end
        checks++; if (o_valid !== 1'b1)    begin errors++; $display("FAIL ovf_valid_stalled: got %b required 1", o_valid); end
        wait_drain(0, ok);
        checks++; if (!ok)          begin errors++; $display("FAIL ovf_drain: got timeout required drained"); end
        checks++; if (n_out != 864) begin errors++; $display("FAIL ovf_count: got %0d required 864", n_out); end
        checks++; if (o_overflow !== 1'b1) begin errors++; $display("FAIL ovf_after_drain: got %b required 1", o_overflow); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit hit;
        i_ready = 1'b1;
        drive_beats(0, 0, 69);
        reset = 1'b1;
        @(negedge clk);
        checks++; if (o_valid !== 1'b0)    begin errors++; $display("FAIL rstmid_w_valid: got %b required 0", o_valid); end
        checks++; if (o_busy !== 1'b0)     begin errors++; $display("FAIL rstmid_w_busy: got %b required 0", o_busy); end
        checks++; if (o_overflow !== 1'b0) begin errors++; $display("FAIL rstmid_w_overflow: got %b required 0", o_overflow); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb.delete();
        n_out = 0;
        drive_beats(0, 0, N_POOL - 1);
        push_frame(0);
        hit = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (n_out >= 200) begin
                hit = 1'b1;
                break;
            end
        end
        checks++; if (!hit) begin errors++; $display("FAIL rstmid_reach200: got %0d elems required 200", n_out); end
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rstmid_r_valid: got %b required 0", o_valid); end
        checks++; if (o_busy !== 1'b0)  begin errors++; $display("FAIL rstmid_r_busy: got %b required 0", o_busy); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb.delete();
        n_out = 0;
        drive_beats(2, 0, N_POOL - 1);
        push_frame(2);
        wait_drain(0, ok);
        checks++; if (!ok)          begin errors++; $display("FAIL rstmid_drain: got timeout required drained"); end
        checks++; if (n_out != 432) begin errors++; $display("FAIL rstmid_count: got %0d required 432", n_out); end
    endtask

    task automatic test_negative();
        bit ok;
        do_reset();
        drive_beats(1, 0, N_POOL - 1);
        push_frame(1);
        wait_drain(0, ok);
        checks++; if (!ok)          begin errors++; $display("FAIL neg_drain: got timeout required drained"); end
        checks++; if (n_out != 432) begin errors++; $display("FAIL neg_count: got %0d required 432", n_out); end
    endtask

    task automatic test_release_write();
        bit ok;
        bit found;
        do_reset();
        i_ready = 1'b0;
        drive_beats(2, 0, N_POOL - 1);
        push_frame(2);
        drive_beats(3, 0, N_POOL - 1);
        push_frame(3);
        i_ready = 1'b1;
        found   = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (o_valid && o_last) begin
                found = 1'b1;
                break;
            end
        end
        checks++; if (!found) begin errors++; $display("FAIL relw_last_seen: got none required o_last"); end
        // First beat of the next frame lands on the same edge as the o_last handshake.
        i_valid = 1'b1;
        i_fmap  = beat(4, 0);
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        checks++; if (o_overflow !== 1'b0) begin errors++; $display("FAIL relw_overflow: got %b required 0", o_overflow); end
        checks++; if (o_valid !== 1'b0)    begin errors++; $display("FAIL relw_fetch_bubble: got %b required 0", o_valid); end
        drive_beats(4, 1, N_POOL - 1);
        push_frame(4);
        wait_drain(0, ok);
        checks++; if (!ok)           begin errors++; $display("FAIL relw_drain: got timeout required drained"); end
        checks++; if (n_out != 1296) begin errors++; $display("FAIL relw_count: got %0d required 1296", n_out); end
        checks++; if (o_overflow !== 1'b0) begin errors++; $display("FAIL relw_overflow_end: got %b required 0", o_overflow); end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "timeout");
    end

    initial begin
        reset   = 1'b1;
        i_valid = 1'b0;
        i_fmap  = '0;
        i_ready = 1'b1;
        test_reset();
        test_stream();
        test_stall();
        test_overflow();
        test_reset_mid();
        test_negative();
        test_release_write();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
